phv_credit_gate: RTL and testbench
==================================

Name: phv_credit_gate

Overview:
- Admission controller between the packet filter and the parser/packet-FIFO fan-out of the RMT pipeline.
- Reserves one PHV-FIFO credit per packet at start-of-packet (SOP), so the stage chain can never overflow the PHV FIFO.
- Owns that PHV FIFO. It is written by the last stage and read by the deparser.
- Parametrised in data width, PHV width, FIFO depth and full-pipeline policy: stall or drop.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, packet data width
C_S_AXIS_TUSER_WIDTH, 128, tuser width
PKT_VEC_WIDTH, 1124, PHV width
PHV_FIFO_DEPTH_BITS, 4, PHV FIFO depth = 2**PHV_FIFO_DEPTH_BITS
DROP_MODE, 0, 0 = stall input when no credit; 1 = drop whole packet when no credit

Ports:
clk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input packet data
s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet
m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  to parser and packet FIFO
m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  byte enables
m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  sideband
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready (packet FIFO not nearly full)
m_axis_tlast  out  1  end of packet
phv_in  in  PKT_VEC_WIDTH  PHV from last stage
phv_in_valid  in  1  PHV write strobe
phv_out  out  PKT_VEC_WIDTH  FIFO head, first-word fall-through
phv_empty  out  1  PHV FIFO empty
phv_rd_en  in  1  deparser pop
credits_used  out  PHV_FIFO_DEPTH_BITS+1  PHVs in flight plus PHVs stored
phv_overflow  out  1  sticky: write while full
pkt_drop_cnt  out  32  dropped packets (optional feature)

Behaviour:
- Reset (aresetn=0 at posedge clk):
  - FSM returns to IDLE.
  - credits_used=0, FIFO pointers=0.
  - phv_empty=1, phv_overflow=0, pkt_drop_cnt=0.
  - s_axis_tready=0, m_axis_tvalid=0.
  - Reset mid-packet abandons the packet; the remaining beats are treated as a new packet.
- credit_avail = (credits_used < 2**PHV_FIFO_DEPTH_BITS).
- FSM states:
  - IDLE
    - credit_avail=1: pass-through is combinational. m_axis_* = s_axis_*, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
    - On the SOP handshake, reserve one credit. If tlast=0, go to PASS; otherwise stay in IDLE.
    - credit_avail=0, DROP_MODE=0: s_axis_tready=0, m_axis_tvalid=0.
    - credit_avail=0, DROP_MODE=1: s_axis_tready=1, m_axis_tvalid=0. On the first beat: if tlast=0, go to DROP; otherwise stay in IDLE and count one drop.
  - PASS: pass-through as above, regardless of credits. On a tlast handshake, go to IDLE.
  - DROP: s_axis_tready=1, m_axis_tvalid=0. On tlast&tvalid, go to IDLE and count one drop.
- Credits:
  - +1 on SOP acceptance in IDLE.
  - -1 on phv_rd_en & ~phv_empty.
  - Both in the same cycle: net 0.
  - A pop when empty is ignored.
  - The credit count never underflows.
- PHV FIFO:
  - Depth 2**PHV_FIFO_DEPTH_BITS, first-word fall-through.
  - phv_out is valid the cycle after a write into an empty FIFO.
  - Simultaneous read and write when not empty: count unchanged.
  - Write while full: data discarded, phv_overflow=1 until reset. Credit gating makes this unreachable unless phv_in_valid is spurious.
  - Pointers wrap modulo depth.
- The credit decision is made only at SOP; mid-packet beats are never stalled for credit.
- Latency: packet path 0 cycles, combinational; PHV FIFO 1 cycle.

Optional Feature:
- PHV_GATE_STATS_EN defined:
  - pkt_drop_cnt increments once per dropped packet and saturates at 0xFFFFFFFF.
  - Only meaningful with DROP_MODE=1.
- Not defined:
  - pkt_drop_cnt tied to 0; no counter logic.
  - Packets are still dropped per DROP_MODE.

Test Plan:
- Depth 4, DROP_MODE=0: send 4 single-beat packets, no phv_in, no pops.
  - credits_used reaches 4.
  - 5th packet sees s_axis_tready=0 until phv_in_valid and one phv_rd_en; 5th packet is accepted in the next cycle.
- Send a 3-beat packet with m_axis_tready toggling 1,0,1,1.
  - All beats appear on m_axis in order with tlast on beat 3.
  - credits_used increments by exactly 1 at SOP.
- DROP_MODE=1, stats enabled, credits full: send a 2-beat packet.
  - s_axis_tready=1 on both beats, m_axis_tvalid=0.
  - pkt_drop_cnt goes 0->1; credits_used unchanged.
- Simultaneous SOP acceptance and phv_rd_en at credits_used=2: credits_used stays 2.
- Write 5 PHVs into a depth-4 FIFO with no reads.
  - phv_overflow=1 and stays 1.
  - Reads return values 1..4 in order; phv_empty=1 after the 4th pop.
- Assert aresetn=0 mid-PASS after beat 2 of 4, then release.
  - credits_used=0, phv_empty=1.
  - Next beat is treated as SOP and reserves 1 credit.

Source files
------------

// File: rtl/phv_credit_gate_if.sv
// phv_credit_gate_if: AXI4-Stream bundle used on both sides of the credit gate.
//   tdata/tkeep/tuser/tvalid/tlast : source -> sink
//   tready                         : sink -> source
// Modports: master (drives the stream), slave (receives the stream).
interface phv_credit_gate_if #(
  parameter int DATA_W  = 256,
  parameter int TUSER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [TUSER_W-1:0]  tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/phv_credit_gate.sv
// phv_credit_gate: admission controller in front of the parser / packet FIFO.
// Reserves one PHV-FIFO credit per packet at SOP so the stage chain can never
// overflow the PHV FIFO, and owns that FIFO (written by the last stage, read
// by the deparser, first-word fall-through).
//
// Ports:
//   clk, aresetn       clock, synchronous active-low reset
//   s_axis (slave)     packet stream from the filter
//   m_axis (master)    packet stream to parser / packet FIFO (0-cycle path)
//   phv_in/phv_in_valid  PHV write from the last stage
//   phv_out/phv_empty/phv_rd_en  FIFO head (FWFT) and deparser pop
//   credits_used       PHVs in flight plus PHVs stored
//   phv_overflow       sticky: write attempted while FIFO full
//   pkt_drop_cnt       dropped packets (counter exists only with
//                      PHV_GATE_STATS_EN defined, otherwise tied to 0)
//
// DROP_MODE: 0 = hold s_axis_tready low when no credit at SOP,
//            1 = swallow the whole packet when no credit at SOP.
module phv_credit_gate #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_VEC_WIDTH        = 1124,
  parameter int PHV_FIFO_DEPTH_BITS  = 4,
  parameter int DROP_MODE            = 0
) (
  input  logic                         clk,
  input  logic                         aresetn,
  phv_credit_gate_if.slave             s_axis,
  phv_credit_gate_if.master            m_axis,
  input  logic [PKT_VEC_WIDTH-1:0]     phv_in,
  input  logic                         phv_in_valid,
  output logic [PKT_VEC_WIDTH-1:0]     phv_out,
  output logic                         phv_empty,
  input  logic                         phv_rd_en,
  output logic [PHV_FIFO_DEPTH_BITS:0] credits_used,
  output logic                         phv_overflow,
  output logic [31:0]                  pkt_drop_cnt
);
  localparam int CNT_W = PHV_FIFO_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << PHV_FIFO_DEPTH_BITS;
  localparam int PTR_W = PHV_FIFO_DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t state, state_nxt;

  logic credit_avail, sop_take, pop, s_ready, m_valid;

  assign credit_avail = credits_used < CNT_W'(DEPTH);
  // Credit is reserved only on the SOP handshake taken in IDLE.
  assign sop_take = (state == IDLE) && credit_avail && s_axis.tvalid && m_axis.tready;

  // Data path is pure wiring; only valid/ready are steered by the FSM.
  assign m_axis.tdata = s_axis.tdata[C_S_AXIS_DATA_WIDTH-1:0];
  assign m_axis.tkeep = s_axis.tkeep[C_S_AXIS_DATA_WIDTH/8-1:0];
  assign m_axis.tuser = s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:0];
  assign m_axis.tlast = s_axis.tlast;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (credit_avail) begin
          if (s_axis.tvalid && m_axis.tready && !s_axis.tlast) state_nxt = PASS;
        end else if (DROP_MODE != 0) begin
          if (s_axis.tvalid && !s_axis.tlast) state_nxt = DROP;
        end
      end
      PASS: if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_nxt = IDLE;
      DROP: if (s_axis.tvalid && s_axis.tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (credit_avail) begin
          s_ready = m_axis.tready;
          m_valid = s_axis.tvalid;
        end else if (DROP_MODE != 0) begin
          s_ready = 1'b1;
        end
      end
      // Mid-packet beats are never held back for credit.
      PASS: begin
        s_ready = m_axis.tready;
        m_valid = s_axis.tvalid;
      end
      DROP: s_ready = 1'b1;
      default: ;
    endcase
  end

  // Keep the handshake closed while reset is asserted.
  assign s_axis.tready = s_ready & aresetn;
  assign m_axis.tvalid = m_valid & aresetn;

  // ---------------- credits ----------------
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      credits_used <= '0;
    end else begin
      case ({sop_take, pop})
        2'b10: credits_used <= credits_used + CNT_W'(1);
        // Guard against underflow if spurious PHV writes filled the FIFO.
        2'b01: if (credits_used != '0) credits_used <= credits_used - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------- PHV FIFO (FWFT) ----------------
  logic [PKT_VEC_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt;
  logic                     fifo_full, wr_ok;

  assign fifo_full = fifo_cnt == CNT_W'(DEPTH);
  assign phv_empty = fifo_cnt == '0;
  assign wr_ok     = phv_in_valid && !fifo_full;
  assign pop       = phv_rd_en && !phv_empty;
  assign phv_out   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= phv_in;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      phv_overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: ;
      endcase
      if (phv_in_valid && fifo_full) phv_overflow <= 1'b1;
    end
  end

  // ---------------- drop statistics ----------------
`ifdef PHV_GATE_STATS_EN
  logic        drop_done;
  logic [31:0] drop_cnt_q;

  // A packet is counted as dropped on its tlast beat: either a single-beat
  // packet refused in IDLE, or the end of a packet being swallowed in DROP.
  assign drop_done = s_axis.tvalid && s_axis.tlast &&
                     ((state == DROP) ||
                      ((state == IDLE) && !credit_avail && (DROP_MODE != 0)));

  always_ff @(posedge clk) begin
    if (!aresetn)                         drop_cnt_q <= '0;
    else if (drop_done && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
  end

  assign pkt_drop_cnt = drop_cnt_q;
`else
  assign pkt_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_phv_credit_gate.sv
module tb_phv_credit_gate;
  localparam int DW = 32, UW = 8, PW = 16, DB = 2;

`ifdef PHV_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  phv_credit_gate_if #(.DATA_W(DW), .TUSER_W(UW)) sa(), ma(), sb(), mb();

  logic [PW-1:0] phv_in_a, phv_in_b, phv_out_a, phv_out_b;
  logic          pv_a, pv_b, pr_a, pr_b, empty_a, empty_b, ovf_a, ovf_b;
  logic [DB:0]   cr_a, cr_b;
  logic [31:0]   drop_a, drop_b;

  phv_credit_gate #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
    .PKT_VEC_WIDTH(PW), .PHV_FIFO_DEPTH_BITS(DB), .DROP_MODE(0)) dut_a (
    .clk(clk), .aresetn(rst_a), .s_axis(sa), .m_axis(ma),
    .phv_in(phv_in_a), .phv_in_valid(pv_a), .phv_out(phv_out_a),
    .phv_empty(empty_a), .phv_rd_en(pr_a), .credits_used(cr_a),
    .phv_overflow(ovf_a), .pkt_drop_cnt(drop_a));

  phv_credit_gate #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
    .PKT_VEC_WIDTH(PW), .PHV_FIFO_DEPTH_BITS(DB), .DROP_MODE(1)) dut_b (
    .clk(clk), .aresetn(rst_b), .s_axis(sb), .m_axis(mb),
    .phv_in(phv_in_b), .phv_in_valid(pv_b), .phv_out(phv_out_b),
    .phv_empty(empty_b), .phv_rd_en(pr_b), .credits_used(cr_b),
    .phv_overflow(ovf_b), .pkt_drop_cnt(drop_b));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic sv, sl, mr, pv, pr;   // s_tvalid, s_tlast, m_tready, phv_in_valid, phv_rd_en
    logic ex_sr, ex_mv;         // expected s_tready, m_tvalid (same cycle)
    logic [DB:0] ex_cr;         // expected credits_used after the edge
  } vec_t;

  vec_t vecs[13];

  initial begin
    // 4 single-beat packets fill credits, 5th stalls until a PHV is written
    // and popped, then enters; afterwards drain and test SOP + pop together.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2};

    sa.tdata = '0; sa.tkeep = '1; sa.tuser = 8'h5A; sa.tvalid = 1'b1; sa.tlast = 1'b1;
    sb.tdata = '0; sb.tkeep = '1; sb.tuser = 8'hA5; sb.tvalid = 1'b1; sb.tlast = 1'b1;
    ma.tready = 1'b1; mb.tready = 1'b1;
    phv_in_a = '0; phv_in_b = '0; pv_a = 1'b0; pv_b = 1'b0; pr_a = 1'b0; pr_b = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;

    // ---- reset state ----
    tick();
    chk("rst_credits_a", cr_a, 0);
    chk("rst_empty_a", empty_a, 1);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_sready_a", sa.tready, 0);
    chk("rst_mvalid_a", ma.tvalid, 0);
    chk("rst_credits_b", cr_b, 0);
    chk("rst_drop_b", drop_b, 0);
    chk("rst_sready_b", sb.tready, 0);
    sa.tvalid = 1'b0; sb.tvalid = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    // ---- table-driven credit sequence on the stall-mode instance ----
    for (int i = 0; i < 13; i++) begin
      sa.tvalid = vecs[i].sv; sa.tlast = vecs[i].sl; sa.tdata = 32'h1000 + i;
      ma.tready = vecs[i].mr; pv_a = vecs[i].pv; pr_a = vecs[i].pr;
      phv_in_a = 16'hA000 + 16'(i);
      #1;
      chk($sformatf("vec%0d_sready", i), sa.tready, vecs[i].ex_sr);
      chk($sformatf("vec%0d_mvalid", i), ma.tvalid, vecs[i].ex_mv);
      if (vecs[i].ex_mv) chk($sformatf("vec%0d_mdata", i), ma.tdata, 32'h1000 + i);
      tick();
      chk($sformatf("vec%0d_credits", i), cr_a, vecs[i].ex_cr);
    end
    sa.tvalid = 1'b0; pv_a = 1'b0; pr_a = 1'b0;

    // ---- 3-beat packet, m_tready 1,0,1,1 ----
    sa.tvalid = 1'b1; sa.tlast = 1'b0; sa.tdata = 32'hB0; ma.tready = 1'b1;
    #1;
    chk("p3_b0_mvalid", ma.tvalid, 1);
    chk("p3_b0_mdata", ma.tdata, 32'hB0);
    chk("p3_b0_mlast", ma.tlast, 0);
    chk("p3_b0_muser", ma.tuser, 8'h5A);
    tick();
    chk("p3_sop_credits", cr_a, 3);
    sa.tdata = 32'hB1; ma.tready = 1'b0;
    #1;
    chk("p3_b1_sready_low", sa.tready, 0);
    chk("p3_b1_mvalid", ma.tvalid, 1);
    chk("p3_b1_mdata", ma.tdata, 32'hB1);
    tick();
    ma.tready = 1'b1;
    #1;
    chk("p3_b1_sready", sa.tready, 1);
    tick();
    sa.tdata = 32'hB2; sa.tlast = 1'b1;
    #1;
    chk("p3_b2_mdata", ma.tdata, 32'hB2);
    chk("p3_b2_mlast", ma.tlast, 1);
    tick();
    chk("p3_end_credits", cr_a, 3);
    sa.tvalid = 1'b0;

    // ---- drop mode: fill credits, then a 2-beat packet is swallowed ----
    for (int i = 0; i < 4; i++) begin
      sb.tvalid = 1'b1; sb.tlast = 1'b1;
      tick();
    end
    chk("drop_fill_credits", cr_b, 4);
    sb.tlast = 1'b0;
    #1;
    chk("drop_b0_sready", sb.tready, 1);
    chk("drop_b0_mvalid", mb.tvalid, 0);
    tick();
    sb.tlast = 1'b1;
    #1;
    chk("drop_b1_sready", sb.tready, 1);
    chk("drop_b1_mvalid", mb.tvalid, 0);
    tick();
    sb.tvalid = 1'b0;
    chk("drop_cnt_1", drop_b, STATS ? 32'd1 : 32'd0);
    chk("drop_credits", cr_b, 4);
    sb.tvalid = 1'b1; sb.tlast = 1'b1;
    #1;
    chk("drop_single_mvalid", mb.tvalid, 0);
    tick();
    sb.tvalid = 1'b0;
    chk("drop_cnt_2", drop_b, STATS ? 32'd2 : 32'd0);

    // ---- overflow: 5 writes into depth-4 FIFO, then pop 1..4 ----
    for (int i = 1; i <= 5; i++) begin
      phv_in_b = 16'(i); pv_b = 1'b1;
      tick();
    end
    pv_b = 1'b0;
    chk("ovf_set", ovf_b, 1);
    chk("ovf_not_empty", empty_b, 0);
    pr_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pop%0d_data", i), phv_out_b, 64'(i));
      tick();
    end
    pr_b = 1'b0;
    chk("pop_empty", empty_b, 1);
    chk("ovf_sticky", ovf_b, 1);
    chk("pop_credits", cr_b, 0);

    // ---- reset mid-PASS after beat 2 of 4 ----
    phv_in_a = 16'h77; pv_a = 1'b1;
    tick();
    pv_a = 1'b0;
    chk("mr_pre_empty", empty_a, 0);
    sa.tvalid = 1'b1; sa.tlast = 1'b0; ma.tready = 1'b1;
    tick();
    chk("mr_sop_credits", cr_a, 4);
    tick();
    rst_a = 1'b0;
    #1;
    chk("mr_rst_sready", sa.tready, 0);
    tick();
    rst_a = 1'b1;
    chk("mr_credits", cr_a, 0);
    chk("mr_empty", empty_a, 1);
    chk("mr_ovf", ovf_a, 0);
    #1;
    chk("mr_b2_sready", sa.tready, 1);
    tick();
    chk("mr_new_sop_credits", cr_a, 1);
    sa.tlast = 1'b1;
    tick();
    chk("mr_end_credits", cr_a, 1);
    sa.tvalid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
